// File: rtl/tfg_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tfg_arbiter
// Purpose  : Round-robin arbiter that shares one twiddle-factor generator (TFG)
//            among NUM_REQ requesters. It captures the winner's parameters,
//            issues a one-cycle start pulse and counts the returned beats.
//            When the job is complete it sends a one-hot acknowledge.
// Ports    : clk, rst            - clock, synchronous active-high reset
//            i_req               - per-requester request level
//            i_phi/i_q/i_t       - per-requester seed / modulus / constant
//            i_log2N             - per-requester transform size exponent
//            o_tfg_valid         - start pulse to the TFG
//            o_tfg_phi/q/t/log2N - registered parameters of the granted job
//            i_tfg_valid         - TFG output-beat valid
//            o_stream_valid      - i_tfg_valid gated to counted job beats
//            o_gnt_id            - index of the requester owning the TFG
//            o_ack               - one-hot job-complete pulse
//            o_busy              - arbiter not idle
//            o_err               - watchdog expiry (TFG_ARB_WATCHDOG_EN only)
// Option   : define TFG_ARB_WATCHDOG_EN to enable the beat watchdog
// Revision : 1.0 - initial release
// ============================================================================
module tfg_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int MAX_BW  = 62,
    parameter int N_LANES = 16,
    parameter int TIMEOUT = 1023
) (
    input  logic                                          clk,
    input  logic                                          rst,
    input  logic [NUM_REQ-1:0]                            i_req,
    input  logic [NUM_REQ*MAX_BW-1:0]                     i_phi,
    input  logic [NUM_REQ*MAX_BW-1:0]                     i_q,
    input  logic [NUM_REQ*(MAX_BW+1)-1:0]                 i_t,
    input  logic [NUM_REQ*4-1:0]                          i_log2N,
    output logic                                          o_tfg_valid,
    output logic [MAX_BW-1:0]                             o_tfg_phi,
    output logic [MAX_BW-1:0]                             o_tfg_q,
    output logic [MAX_BW:0]                               o_tfg_t,
    output logic [3:0]                                    o_tfg_log2N,
    input  logic                                          i_tfg_valid,
    output logic                                          o_stream_valid,
    output logic [((NUM_REQ > 1) ? $clog2(NUM_REQ) : 1)-1:0] o_gnt_id,
    output logic [NUM_REQ-1:0]                            o_ack,
    output logic                                          o_busy
`ifdef TFG_ARB_WATCHDOG_EN
    ,
    output logic                                          o_err
`endif
);

    localparam int ID_W       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int LOG2_LANES = $clog2(N_LANES);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ISSUE  = 3'd1,
        S_WAIT   = 3'd2,
        S_STREAM = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    state_t             r_state;
    state_t             w_next;
    logic [ID_W-1:0]    r_last;
    logic [ID_W-1:0]    r_gnt;
    logic [15:0]        r_beat;
    logic [MAX_BW-1:0]  r_phi;
    logic [MAX_BW-1:0]  r_q;
    logic [MAX_BW:0]    r_t;
    logic [3:0]         r_log2n;

    logic [ID_W:0]      w_idx;
    logic [ID_W-1:0]    w_win;
    logic               w_found;
    logic [3:0]         w_shift;
    logic [15:0]        w_total;
    logic [15:0]        w_beat_inc;
    logic               w_active;
    logic               w_wd_expire;

    // Round-robin search starting one past the last winner; the extra index
    // bit lets the sum wrap without a true modulo.
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        w_idx   = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            w_idx = {1'b0, r_last} + (ID_W+1)'(i);
            if (w_idx >= (ID_W+1)'(NUM_REQ)) begin
                w_idx = w_idx - (ID_W+1)'(NUM_REQ);
            end
            if (!w_found && i_req[w_idx[ID_W-1:0]]) begin
                w_found = 1'b1;
                w_win   = w_idx[ID_W-1:0];
            end
        end
    end

    // Beat total = max(1, 2^log2N / N_LANES) as a shift of one.
    always_comb begin
        w_shift = 4'd0;
        if (int'(r_log2n) > LOG2_LANES) begin
            w_shift = r_log2n - 4'(LOG2_LANES);
        end
        w_total = 16'd1 << w_shift;
    end

    assign w_beat_inc = r_beat + 16'd1;
    assign w_active   = (r_state == S_WAIT) || (r_state == S_STREAM);

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (w_found) w_next = S_ISSUE;
            S_ISSUE:  w_next = S_WAIT;
            S_WAIT,
            S_STREAM: begin
                if (i_tfg_valid) begin
                    w_next = (w_beat_inc == w_total) ? S_DONE : S_STREAM;
                end else if (w_wd_expire) begin
                    w_next = S_DONE;
                end
            end
            S_DONE:   w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_last  <= ID_W'(NUM_REQ - 1);
            r_gnt   <= '0;
            r_beat  <= '0;
            r_phi   <= '0;
            r_q     <= '0;
            r_t     <= '0;
            r_log2n <= '0;
        end else begin
            r_state <= w_next;
            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_gnt   <= w_win;
                        r_phi   <= i_phi[int'(w_win)*MAX_BW +: MAX_BW];
                        r_q     <= i_q[int'(w_win)*MAX_BW +: MAX_BW];
                        r_t     <= i_t[int'(w_win)*(MAX_BW+1) +: (MAX_BW+1)];
                        r_log2n <= i_log2N[int'(w_win)*4 +: 4];
                    end
                end
                S_ISSUE: r_beat <= '0;
                S_WAIT,
                S_STREAM: if (i_tfg_valid) r_beat <= w_beat_inc;
                S_DONE: begin
                    r_last <= r_gnt;
                    r_beat <= '0;
                end
                default: ;
            endcase
        end
    end

`ifdef TFG_ARB_WATCHDOG_EN
    localparam int WD_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

    logic [WD_W-1:0] r_wd;
    logic            r_err;

    // Expiry is flagged one count early so DONE is entered on the cycle the
    // counter would reach TIMEOUT.
    assign w_wd_expire = w_active && !i_tfg_valid && (r_wd == WD_W'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wd  <= '0;
            r_err <= 1'b0;
        end else begin
            if (r_state == S_ISSUE || (w_active && i_tfg_valid)) begin
                r_wd <= '0;
            end else if (w_active) begin
                r_wd <= r_wd + 1'b1;
            end
            if (r_state == S_DONE) begin
                r_err <= 1'b0;
            end else if (w_wd_expire) begin
                r_err <= 1'b1;
            end
        end
    end

    assign o_err = (r_state == S_DONE) && r_err;
`else
    logic w_unused_timeout;

    assign w_wd_expire      = 1'b0;
    assign w_unused_timeout = ^TIMEOUT;
`endif

    assign o_tfg_valid    = (r_state == S_ISSUE);
    assign o_busy         = (r_state != S_IDLE);
    assign o_ack          = (r_state == S_DONE) ? (NUM_REQ'(1) << r_gnt) : '0;
    assign o_stream_valid = i_tfg_valid && w_active && (r_beat < w_total);
    assign o_gnt_id       = r_gnt;
    assign o_tfg_phi      = r_phi;
    assign o_tfg_q        = r_q;
    assign o_tfg_t        = r_t;
    assign o_tfg_log2N    = r_log2n;

endmodule
`default_nettype wire

// File: tb/tb_tfg_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_tfg_arbiter
// Purpose  : Scoreboard bench for tfg_arbiter. A transaction-level reference
//            model predicts grants and acknowledges into queues; a monitor
//            pops them when the DUT presents o_tfg_valid or o_ack.
// Revision : 1.0 - initial release
// ============================================================================
module tb_tfg_arbiter;

    localparam int NUM_REQ = 4;
    localparam int MAX_BW  = 62;
    localparam int N_LANES = 16;
    localparam int TIMEOUT = 1023;
    localparam int ID_W    = 2;

    logic                          clk = 1'b0;
    logic                          rst;
    logic [NUM_REQ-1:0]            req;
    logic [NUM_REQ*MAX_BW-1:0]     phi_bus;
    logic [NUM_REQ*MAX_BW-1:0]     q_bus;
    logic [NUM_REQ*(MAX_BW+1)-1:0] t_bus;
    logic [NUM_REQ*4-1:0]          l2_bus;
    logic                          tfg_v;

    logic                          o_tfg_valid;
    logic [MAX_BW-1:0]             o_tfg_phi;
    logic [MAX_BW-1:0]             o_tfg_q;
    logic [MAX_BW:0]               o_tfg_t;
    logic [3:0]                    o_tfg_log2N;
    logic                          o_stream_valid;
    logic [ID_W-1:0]               o_gnt_id;
    logic [NUM_REQ-1:0]            o_ack;
    logic                          o_busy;

    tfg_arbiter #(
        .NUM_REQ (NUM_REQ),
        .MAX_BW  (MAX_BW),
        .N_LANES (N_LANES),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .i_req          (req),
        .i_phi          (phi_bus),
        .i_q            (q_bus),
        .i_t            (t_bus),
        .i_log2N        (l2_bus),
        .o_tfg_valid    (o_tfg_valid),
        .o_tfg_phi      (o_tfg_phi),
        .o_tfg_q        (o_tfg_q),
        .o_tfg_t        (o_tfg_t),
        .o_tfg_log2N    (o_tfg_log2N),
        .i_tfg_valid    (tfg_v),
        .o_stream_valid (o_stream_valid),
        .o_gnt_id       (o_gnt_id),
        .o_ack          (o_ack),
        .o_busy         (o_busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int                cyc;
        int                id;
        logic [MAX_BW-1:0] phi;
        logic [MAX_BW-1:0] q;
        logic [MAX_BW:0]   t;
        logic [3:0]        l2;
    } grant_t;

    typedef struct {
        int                 cyc;
        logic [NUM_REQ-1:0] ack;
        int                 beats;
    } ack_t;

    grant_t gq[$];
    ack_t   aq[$];
    int     gids[$];

    int checks     = 0;
    int errors     = 0;
    int cyc        = 0;
    int stream_cnt = 0;
    int ack_total  = 0;
    logic [NUM_REQ-1:0] ack_last = '0;

    int tfg_mode   = 0;   // 0 random, 1 always, 2 alternate, 3 never
    bit auto_raise = 1'b0;
    bit hold       = 1'b0;

    // ---------------- reference model (job-level) ----------------
    int m_phase = 0;      // 0 free, 1 start pulse, 2 collecting beats, 3 completing
    int m_last  = NUM_REQ - 1;
    int m_win   = 0;
    int m_beats = 0;
    int m_total = 1;
    int m_w;
    grant_t mg;
    ack_t   ma;

    always @(posedge clk) begin
        cyc = cyc + 1;
        if (rst) begin
            m_phase = 0;
            m_last  = NUM_REQ - 1;
            gq.delete();
            aq.delete();
        end else begin
            case (m_phase)
                0: if (req != '0) begin
                    m_w = -1;
                    for (int i = 1; i <= NUM_REQ; i++) begin
                        if (m_w < 0 && req[(m_last + i) % NUM_REQ]) m_w = (m_last + i) % NUM_REQ;
                    end
                    m_win   = m_w;
                    mg.cyc  = cyc;
                    mg.id   = m_w;
                    mg.phi  = phi_bus[m_w*MAX_BW +: MAX_BW];
                    mg.q    = q_bus[m_w*MAX_BW +: MAX_BW];
                    mg.t    = t_bus[m_w*(MAX_BW+1) +: (MAX_BW+1)];
                    mg.l2   = l2_bus[m_w*4 +: 4];
                    gq.push_back(mg);
                    m_total = (1 << int'(mg.l2)) / N_LANES;
                    if (m_total < 1) m_total = 1;
                    m_phase = 1;
                end
                1: begin
                    m_phase = 2;
                    m_beats = 0;
                end
                2: if (tfg_v) begin
                    m_beats = m_beats + 1;
                    if (m_beats == m_total) begin
                        ma.cyc   = cyc;
                        ma.ack   = NUM_REQ'(1) << m_win;
                        ma.beats = m_total;
                        aq.push_back(ma);
                        m_phase  = 3;
                    end
                end
                default: begin
                    m_last  = m_win;
                    m_phase = 0;
                end
            endcase
        end
    end

    // ---------------- monitor ----------------
    grant_t pg;
    ack_t   pa;

    always @(negedge clk) begin
        ack_last = o_ack;
        if (rst) begin
            stream_cnt = 0;
        end else begin
            if (o_tfg_valid) begin
                gids.push_back(int'(o_gnt_id));
                checks = checks + 1;
                if (gq.size() == 0) begin
                    errors = errors + 1;
                    $display("FAIL grant_unexpected: got id %0d at cycle %0d, required no grant", o_gnt_id, cyc);
                end else begin
                    pg = gq.pop_front();
                    if (cyc != pg.cyc || int'(o_gnt_id) != pg.id || o_tfg_phi != pg.phi ||
                        o_tfg_q != pg.q || o_tfg_t != pg.t || o_tfg_log2N != pg.l2) begin
                        errors = errors + 1;
                        $display("FAIL grant: got cyc %0d id %0d log2N %0d phi %0h, required cyc %0d id %0d log2N %0d phi %0h",
                                 cyc, o_gnt_id, o_tfg_log2N, o_tfg_phi, pg.cyc, pg.id, pg.l2, pg.phi);
                    end
                end
            end
            if (o_stream_valid) begin
                stream_cnt = stream_cnt + 1;
                checks     = checks + 1;
                if (m_phase != 2) begin
                    errors = errors + 1;
                    $display("FAIL stream_extra: got o_stream_valid 1 at cycle %0d, required 0", cyc);
                end
            end
            if (o_ack != '0) begin
                ack_total = ack_total + 1;
                checks    = checks + 1;
                if (aq.size() == 0) begin
                    errors = errors + 1;
                    $display("FAIL ack_unexpected: got %b at cycle %0d, required none", o_ack, cyc);
                end else begin
                    pa = aq.pop_front();
                    if (cyc != pa.cyc || o_ack != pa.ack || stream_cnt != pa.beats || !o_busy) begin
                        errors = errors + 1;
                        $display("FAIL ack: got cyc %0d ack %b beats %0d busy %0b, required cyc %0d ack %b beats %0d busy 1",
                                 cyc, o_ack, stream_cnt, o_busy, pa.cyc, pa.ack, pa.beats);
                    end
                end
                stream_cnt = 0;
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        checks = checks + 1;
        if (got !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got %0h, required %0h", nm, got, exp);
        end
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_tfg_valid"}, 64'(o_tfg_valid), 64'd0);
        chk({tag, "_stream"},    64'(o_stream_valid), 64'd0);
        chk({tag, "_ack"},       64'(o_ack), 64'd0);
        chk({tag, "_busy"},      64'(o_busy), 64'd0);
        chk({tag, "_gnt_id"},    64'(o_gnt_id), 64'd0);
        chk({tag, "_phi"},       64'(o_tfg_phi), 64'd0);
        chk({tag, "_q"},         64'(o_tfg_q), 64'd0);
        chk({tag, "_t"},         64'(o_tfg_t), 64'd0);
        chk({tag, "_log2N"},     64'(o_tfg_log2N), 64'd0);
    endtask

    task automatic raise(input int k, input int l2);
        req[k] = 1'b1;
        phi_bus[k*MAX_BW +: MAX_BW]         = MAX_BW'({$urandom(), $urandom()});
        q_bus[k*MAX_BW +: MAX_BW]           = MAX_BW'({$urandom(), $urandom()});
        t_bus[k*(MAX_BW+1) +: (MAX_BW+1)]   = (MAX_BW+1)'({$urandom(), $urandom()});
        l2_bus[k*4 +: 4]                    = 4'(l2);
    endtask

    task automatic step();
        @(posedge clk);
        #2;
        case (tfg_mode)
            0:       tfg_v = ($urandom_range(0, 2) != 0);
            1:       tfg_v = 1'b1;
            2:       tfg_v = !tfg_v;
            default: tfg_v = 1'b0;
        endcase
        for (int k = 0; k < NUM_REQ; k++) begin
            if (req[k]) begin
                if (ack_last[k] && !hold) req[k] = 1'b0;
            end else if (auto_raise && $urandom_range(0, 3) == 0) begin
                raise(k, int'($urandom_range(0, 8)));
            end
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req = '0;
        repeat (2) step();
        rst = 1'b0;
    endtask

    task automatic wait_acks(input int n, input int bound, input string nm);
        int start;
        start = ack_total;
        for (int i = 0; i < bound; i++) begin
            if (ack_total - start >= n) break;
            step();
        end
        chk({nm, "_acks_seen"}, 64'(ack_total - start >= n), 64'd1);
    endtask

    task automatic drain(input string nm);
        auto_raise = 1'b0;
        hold       = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            if (req == '0 && m_phase == 0 && gq.size() == 0 && aq.size() == 0) break;
            step();
        end
        chk({nm, "_drained"}, 64'(req == '0 && m_phase == 0 && gq.size() == 0 && aq.size() == 0), 64'd1);
    endtask

    // ---------------- test sequence ----------------
    int exp_order[5] = '{0, 1, 2, 3, 0};
    int n0;

    initial begin
        rst     = 1'b1;
        req     = '0;
        phi_bus = '0;
        q_bus   = '0;
        t_bus   = '0;
        l2_bus  = '0;
        tfg_v   = 1'b0;
        tfg_mode = 3;
        repeat (3) step();
        check_zero("reset");
        rst = 1'b0;

        // single request, 16 beats back to back
        tfg_mode = 1;
        raise(0, 8);
        wait_acks(1, 100, "single");
        chk("single_busy_after", 64'(o_busy), 64'd0);

        // gapped stream, 4 beats, then extra beats while idle
        tfg_mode = 2;
        raise(1, 6);
        wait_acks(1, 100, "gapped");
        repeat (6) step();

        // contention with all requests held, one beat each
        do_reset();
        hold     = 1'b1;
        tfg_mode = 1;
        n0       = gids.size();
        for (int k = 0; k < NUM_REQ; k++) raise(k, 4);
        wait_acks(5, 200, "contention");
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("contention_grant%0d", i),
                64'((gids.size() > n0 + i) ? gids[n0 + i] : -1), 64'(exp_order[i]));
        end
        req = '0;
        drain("contention");

        // reset in the middle of a 16-beat stream
        tfg_mode = 1;
        raise(0, 8);
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            #1;
            if (stream_cnt >= 3) break;
        end
        chk("midrst_reached_beat3", 64'(stream_cnt >= 3), 64'd1);
        rst = 1'b1;
        @(negedge clk);
        #1;
        check_zero("midrst");
        @(posedge clk);
        #2;
        rst = 1'b0;
        req = '0;
        n0  = gids.size();
        for (int k = 0; k < NUM_REQ; k++) raise(k, 4);
        for (int i = 0; i < 20; i++) begin
            if (gids.size() > n0) break;
            step();
        end
        chk("midrst_first_grant", 64'((gids.size() > n0) ? gids[n0] : -1), 64'd0);
        drain("midrst");

        // randomized traffic
        auto_raise = 1'b1;
        tfg_mode   = 0;
        repeat (3000) step();
        drain("random");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
